pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register, the generalised successor to the fixed EX→MEM latch. It moves an opaque payload bundle from stage N to stage N+1 on each rising clock edge. It honours the shared stall vector, inserting a bubble when stage N stalls and stage N+1 runs, and it carries a valid bit. It adds a flush input for exception or branch squash, and it buffers multi-cycle execution state (temporary accumulator plus iteration counter) across stall cycles. It is instantiated between any two adjacent pipeline stages (ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- STAGE, 3: index of this register's upstream stage in `stall`. Own hold is `stall[STAGE]`; downstream hold is `stall[STAGE+1]`. Legal range is 0..STALL_W-2.
- STALL_W, 6: width of the stall vector.
- DATA_W, 103: payload width (e.g. wd 5 + wreg 1 + wdata 32 + whilo 1 + hi 32 + lo 32).
- STATE_W, 64: multi-cycle temporary state width.
- CNT_W, 2: multi-cycle iteration counter width.

Ports:
- clk  in  1  rising-edge clock; the block has one clock.
- rst  in  1  reset; asynchronous and active-high.
- stall  in  STALL_W  global stall vector; 1 = Stop.
- flush  in  1  squash; synchronous, sampled at the clock edge.
- in_valid  in  1  upstream slot holds a real instruction.
- in_payload  in  DATA_W  upstream bundle.
- out_valid  out  1  registered valid.
- out_payload  out  DATA_W  registered bundle.
- state_i  in  STATE_W  multi-cycle temp from the execute unit.
- cnt_i  in  CNT_W  multi-cycle iteration count.
- state_o  out  STATE_W  buffered temp, fed back to the execute unit.
- cnt_o  out  CNT_W  buffered count, fed back.
- stall_cycles  out  16  saturating count of held/bubble cycles (see Configuration).

## Operation
- Let S = `stall[STAGE]` and D = `stall[STAGE+1]`. Each clock edge evaluates the cases below in priority order.
  1. **flush = 1.** `out_valid`←0, `out_payload`←0, `state_o`←0, `cnt_o`←0. Flush wins over every stall combination.
  2. **S=1, D=0 (bubble).** `out_valid`←0 and `out_payload`←0, which is a NOP because register address 0 = NOPRegAddr and all write enables are disabled. `state_o`←`state_i` and `cnt_o`←`cnt_i`, so the multi-cycle op in the upstream stage keeps its progress.
  3. **S=0 (advance).** `out_valid`←`in_valid`. `out_payload`←`in_payload` when `in_valid`=1, else 0. `state_o`←0 and `cnt_o`←0, because the multi-cycle op has completed or none is in progress.
  4. **S=1, D=1 (hold).** `out_valid` and `out_payload` retain their values. `state_o`←`state_i` and `cnt_o`←`cnt_i`.
- An invalid slot always presents an all-zero payload. Downstream logic may rely on this.
- The block makes no combinational path from any input to any output.

## Timing
- Reset (async, immediate on `rst` rising): `out_valid`=0, `out_payload`=0, `state_o`=0, `cnt_o`=0, `stall_cycles`=0. Outputs stay at these values while `rst`=1.
- Latency: 1 cycle from input to output on advance.
- Bubble lasts exactly as long as the S=1, D=0 condition holds. Each such cycle re-writes zeros.
- Reset asserted mid multi-cycle op: state and count are lost. The execute unit restarts from `cnt`=0.
- Flush asserted together with a stall: the register clears and the state buffer clears. The squashed multi-cycle op must not resume.
- S=0 with D=1 is illegal: upstream advancing while downstream is stopped. The block treats it as advance. The bench flags it as an assertion error.

## Configuration
- `PIPE_STALL_PERF_EN` defined: `stall_cycles` increments by 1 on every edge where S=1 and `flush`=0. It saturates at 16'hFFFF and does not wrap. It is cleared only by `rst`.
- Not defined: the counter logic is omitted and `stall_cycles` is tied to 16'h0000.

## Test plan
- **Reset.** Drive `rst`=1 for 2 cycles with `in_valid`=1 and `in_payload`=all-ones → all outputs 0 during and immediately after reset, with no clock edge required.
- **Advance.** `stall`=6'b000000, `in_valid`=1, `in_payload`=103'h5A... → `out_payload` equals it one edge later. Then `in_valid`=0 → `out_valid`=0 and `out_payload`=0.
- **Bubble with multi-cycle buffering.** STAGE=3, `stall`=6'b001111, `state_i`=64'h0000_0001_FFFF_FFFE, `cnt_i`=2'b01 → `out_valid`=0 and `out_payload`=0. `state_o` and `cnt_o` match the inputs after the edge. Next `stall`=0 → `cnt_o`=0 and `state_o`=0.
- **Hold.** `stall`=6'b011111 for 3 cycles after loading payload P → `out_payload`=P for all 3 cycles. `state_o` tracks `state_i` each cycle.
- **Flush priority.** `flush`=1 with `stall`=6'b001111 and `cnt_i`=2'b10 → `out_valid`=0 and `cnt_o`=0. With `PIPE_STALL_PERF_EN` defined, `stall_cycles` is unchanged on that edge.
- **Counter saturation.** With `PIPE_STALL_PERF_EN` defined, hold S=1 for 65540 cycles → `stall_cycles`=16'hFFFF. Without the macro → 0 throughout.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/bubble/flush handling and multi-cycle state buffering.
// Optional stall-cycle performance counter enabled by defining PIPE_STALL_PERF_EN.
module pipe_stage_reg #(
   parameter int STAGE   = 3,
   parameter int STALL_W = 6,
   parameter int DATA_W  = 103,
   parameter int STATE_W = 64,
   parameter int CNT_W   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_payload,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_payload,
   input  logic [STATE_W-1:0] state_i,
   input  logic [CNT_W-1:0]   cnt_i,
   output logic [STATE_W-1:0] state_o,
   output logic [CNT_W-1:0]   cnt_o,
   output logic [15:0]        stall_cycles
);

   logic               own_stall;
   logic               down_stall;
   logic               unused_stall_bits;
   logic               out_valid_reg;
   logic [DATA_W-1:0]  out_payload_reg;
   logic [STATE_W-1:0] state_reg;
   logic [CNT_W-1:0]   cnt_reg;

   assign own_stall         = stall[STAGE];
   assign down_stall        = stall[STAGE+1];
   assign unused_stall_bits = ^stall;

   // Advance ignores the downstream stall bit: S=0 with D=1 is illegal and treated as advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg   <= 1'b0;
         out_payload_reg <= '0;
         state_reg       <= '0;
         cnt_reg         <= '0;
      end else if (flush) begin
         out_valid_reg   <= 1'b0;
         out_payload_reg <= '0;
         state_reg       <= '0;
         cnt_reg         <= '0;
      end else if (!own_stall) begin
         out_valid_reg   <= in_valid;
         out_payload_reg <= in_valid ? in_payload : '0;
         state_reg       <= '0;
         cnt_reg         <= '0;
      end else begin
         if (!down_stall) begin
            out_valid_reg   <= 1'b0;
            out_payload_reg <= '0;
         end
         state_reg <= state_i;
         cnt_reg   <= cnt_i;
      end
   end

   assign out_valid   = out_valid_reg;
   assign out_payload = out_payload_reg;
   assign state_o     = state_reg;
   assign cnt_o       = cnt_reg;

`ifdef PIPE_STALL_PERF_EN
   logic [15:0] stall_cycles_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_reg <= '0;
      end else if (own_stall && !flush && (stall_cycles_reg != 16'hFFFF)) begin
         stall_cycles_reg <= stall_cycles_reg + 16'd1;
      end
   end

   assign stall_cycles = stall_cycles_reg;
`else
   assign stall_cycles = 16'h0000;
`endif

endmodule
